// File: rtl/func_seq_pkg.sv
// Shared types and width helper for the exhaustive equivalence-check sequencer.
package func_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        SAMPLE = 2'd2,
        FIN    = 2'd3
    } seq_state_e;

    // Width of the per-minterm mask and truth-table buses.
    function automatic int mask_w(input int n_in);
        return 1 << n_in;
    endfunction

endpackage

// File: rtl/func_seq_settle_timer.sv
// Settle timer: counts cycles a vector has been held; expire marks the last hold cycle.
module func_seq_settle_timer #(
    parameter int SETTLE = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expire
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = '0;
        end else if (en && !expire) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == CW'(SETTLE - 1));

endmodule

// File: rtl/func_equiv_sequencer.sv
// Sweeps every input vector, compares canonical vs minimized function outputs.
// Optional truth-table capture is built when FUNC_SEQ_TRUTH_CAPTURE_EN is defined.
module func_equiv_sequencer
    import func_seq_pkg::*;
#(
    parameter int  N_IN   = 3,
    parameter int  SETTLE = 2,
    localparam int MW     = mask_w(N_IN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    output logic [N_IN-1:0] vec,
    input  logic            f_ref,
    input  logic            f_min,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [MW-1:0]   mismatch_mask,
    output logic [N_IN-1:0] first_fail,
    output logic [MW-1:0]   tt_ref,
    output logic [MW-1:0]   tt_min,
    output logic [1:0]      state_dbg
);

    // Control handshake: start is taken only in IDLE with abort low; done is a
    // single-cycle pulse and pass/mask/first_fail are final once busy drops.
    localparam logic [N_IN-1:0] VEC_LAST = '1;

    seq_state_e      state_q, state_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic [MW-1:0]   mask_q, mask_d;
    logic [N_IN-1:0] ff_q, ff_d;
    logic            pass_q, pass_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;
    logic            tmr_load;
    logic            tmr_en;
    logic            tmr_expire;
    logic            diff;
    logic            sweep_clear;
    logic            sample_take;

    assign diff = f_ref ^ f_min;

    func_seq_settle_timer #(
        .SETTLE(SETTLE)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (tmr_load),
        .en     (tmr_en),
        .expire (tmr_expire)
    );

    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        mask_d      = mask_q;
        ff_d        = ff_q;
        pass_d      = pass_q;
        tmr_load    = 1'b0;
        tmr_en      = 1'b0;
        sweep_clear = 1'b0;
        sample_take = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    vec_d       = '0;
                    mask_d      = '0;
                    ff_d        = '0;
                    pass_d      = 1'b0;
                    tmr_load    = 1'b1;
                    sweep_clear = 1'b1;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    tmr_en = 1'b1;
                    if (tmr_expire) state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    sample_take   = 1'b1;
                    mask_d[vec_q] = diff;
                    // An all-clear mask means no earlier vector has mismatched.
                    if (diff && (mask_q == '0)) ff_d = vec_q;
                    if (vec_q == VEC_LAST) begin
                        state_d = FIN;
                    end else begin
                        vec_d    = vec_q + N_IN'(1);
                        tmr_load = 1'b1;
                        state_d  = WAIT;
                    end
                end
            end
            FIN: begin
                pass_d  = (mask_q == '0);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        done_d = (state_d == FIN);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= '0;
            mask_q  <= '0;
            ff_q    <= '0;
            pass_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            mask_q  <= mask_d;
            ff_q    <= ff_d;
            pass_q  <= pass_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

`ifdef FUNC_SEQ_TRUTH_CAPTURE_EN
    logic [MW-1:0] tt_ref_q, tt_ref_d;
    logic [MW-1:0] tt_min_q, tt_min_d;

    always_comb begin
        tt_ref_d = tt_ref_q;
        tt_min_d = tt_min_q;
        if (sweep_clear) begin
            tt_ref_d = '0;
            tt_min_d = '0;
        end else if (sample_take) begin
            tt_ref_d[vec_q] = f_ref;
            tt_min_d[vec_q] = f_min;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tt_ref_q <= '0;
            tt_min_q <= '0;
        end else begin
            tt_ref_q <= tt_ref_d;
            tt_min_q <= tt_min_d;
        end
    end

    assign tt_ref = tt_ref_q;
    assign tt_min = tt_min_q;
`else
    logic unused_capture;
    assign unused_capture = sweep_clear ^ sample_take;
    assign tt_ref         = '0;
    assign tt_min         = '0;
`endif

    assign vec           = vec_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign mismatch_mask = mask_q;
    assign first_fail    = ff_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_func_equiv_sequencer.sv
// Bench for func_equiv_sequencer: directed and random function pairs against a truth-table model.
module tb_func_equiv_sequencer;

    localparam int N     = 3;
    localparam int S     = 2;
    localparam int MW    = 8;
    localparam int SWEEP = MW * (S + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [N-1:0]  vec;
    logic          f_ref;
    logic          f_min;
    logic          busy;
    logic          done;
    logic          pass;
    logic [MW-1:0] mismatch_mask;
    logic [N-1:0]  first_fail;
    logic [MW-1:0] tt_ref;
    logic [MW-1:0] tt_min;
    logic [1:0]    state_dbg;

    logic [MW-1:0] ref_tt = '0;
    logic [MW-1:0] min_tt = '0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // The two functions under comparison, as plain truth-table lookups.
    assign f_ref = ref_tt[vec];
    assign f_min = min_tt[vec];

    func_equiv_sequencer #(
        .N_IN   (N),
        .SETTLE (S)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .vec           (vec),
        .f_ref         (f_ref),
        .f_min         (f_min),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .mismatch_mask (mismatch_mask),
        .first_fail    (first_fail),
        .tt_ref        (tt_ref),
        .tt_min        (tt_min),
        .state_dbg     (state_dbg)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Mismatch mask over the first 'upto' minterms.
    function automatic logic [MW-1:0] model_mask(input logic [MW-1:0] r, input logic [MW-1:0] m,
                                                 input int upto);
        logic [MW-1:0] mm;
        mm = '0;
        for (int i = 0; i < upto; i++) mm[i] = (r[i] != m[i]);
        return mm;
    endfunction

    function automatic int model_first(input logic [MW-1:0] mm);
        for (int i = 0; i < MW; i++) if (mm[i]) return i;
        return 0;
    endfunction

    task automatic begin_sweep();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic sweep_and_check(input string tag, input logic [MW-1:0] r,
                                   input logic [MW-1:0] m, input bit spam);
        logic [MW-1:0] exp_mask;
        logic [MW-1:0] exp_tr;
        logic [MW-1:0] exp_tm;
        ref_tt = r;
        min_tt = m;
        begin_sweep();
        for (int k = 0; k <= SWEEP; k++) begin
            check({tag, ":vec"}, 32'(vec), (k < SWEEP) ? k / (S + 1) : MW - 1);
            check({tag, ":busy"}, 32'(busy), 1);
            check({tag, ":done"}, 32'(done), (k == SWEEP) ? 1 : 0);
            if (k < SWEEP) begin
                start = spam ? 1'($urandom_range(0, 1)) : 1'b0;
                @(negedge clk);
            end
        end
        start = 1'b0;
        @(negedge clk);
        exp_mask = model_mask(r, m, MW);
`ifdef FUNC_SEQ_TRUTH_CAPTURE_EN
        exp_tr = r;
        exp_tm = m;
`else
        exp_tr = '0;
        exp_tm = '0;
`endif
        check({tag, ":busy_end"}, 32'(busy), 0);
        check({tag, ":done_end"}, 32'(done), 0);
        check({tag, ":mask"}, 32'(mismatch_mask), 32'(exp_mask));
        check({tag, ":first_fail"}, 32'(first_fail), model_first(exp_mask));
        check({tag, ":pass"}, 32'(pass), (exp_mask == '0) ? 1 : 0);
        check({tag, ":tt_ref"}, 32'(tt_ref), 32'(exp_tr));
        check({tag, ":tt_min"}, 32'(tt_min), 32'(exp_tm));
        check({tag, ":vec_hold"}, 32'(vec), MW - 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ":vec"}, 32'(vec), 0);
        check({tag, ":busy"}, 32'(busy), 0);
        check({tag, ":done"}, 32'(done), 0);
        check({tag, ":pass"}, 32'(pass), 0);
        check({tag, ":mask"}, 32'(mismatch_mask), 0);
        check({tag, ":first_fail"}, 32'(first_fail), 0);
        check({tag, ":tt_ref"}, 32'(tt_ref), 0);
        check({tag, ":tt_min"}, 32'(tt_min), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [MW-1:0] r;
        logic [MW-1:0] flips;
        logic [MW-1:0] part;
        int guard;

        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        #1;
        check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // f_ref = minterms {0,1,2,4,5}; f_min = B' + A'C' covers the same set.
        sweep_and_check("equiv", 8'h37, 8'h37, 1'b0);
        // f_min = B' misses minterm 2.
        sweep_and_check("faulty", 8'h37, 8'h33, 1'b0);
        // f_min = minterms {3,6,7}: every vector disagrees.
        sweep_and_check("disjoint", 8'h37, 8'hC8, 1'b0);
        // Start hammered mid-sweep must not disturb the schedule.
        sweep_and_check("spam_start", 8'h37, 8'h33, 1'b1);

        // Abort while vec==5: only minterms 0..4 have been sampled.
        r = 8'($urandom_range(0, 255));
        ref_tt = r;
        min_tt = ~r;
        begin_sweep();
        guard = 0;
        while (vec !== 3'd5 && guard < SWEEP + 4) begin
            @(negedge clk);
            guard++;
        end
        check("abort:reach_vec5", 32'(vec), 5);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        part = model_mask(r, ~r, 5);
        check("abort:busy", 32'(busy), 0);
        check("abort:done", 32'(done), 0);
        check("abort:mask", 32'(mismatch_mask), 32'(part));
        check("abort:first_fail", 32'(first_fail), model_first(part));
        check("abort:pass", 32'(pass), 0);
        check("abort:vec", 32'(vec), 5);
        @(negedge clk);
        check("abort:done_later", 32'(done), 0);
        check("abort:busy_later", 32'(busy), 0);
        sweep_and_check("after_abort", 8'h37, 8'h37, 1'b0);

        // Start and abort together in IDLE: nothing begins.
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("start_abort:busy", 32'(busy), 0);
        check("start_abort:vec", 32'(vec), MW - 1);
        check("start_abort:pass", 32'(pass), 1);

        // Reset ten cycles into a sweep clears everything without waiting for a clock.
        ref_tt = 8'h37;
        min_tt = 8'h33;
        begin_sweep();
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        @(negedge clk);
        check("mid_reset:done_held", 32'(done), 0);
        rst_n = 1'b1;
        sweep_and_check("after_reset", 8'h37, 8'h33, 1'b0);

        for (int i = 0; i < 6; i++) begin
            r = 8'($urandom_range(0, 255));
            flips = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            sweep_and_check($sformatf("rand%0d", i), r, r ^ flips, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
